// File: rtl/basemul_ctrl.sv
// rtl/basemul_ctrl.sv - sequencer driving one basemul across an NTT-domain Kyber polynomial product
`timescale 1ns/1ps
module basemul_ctrl #(
  parameter int Q         = 3329,
  parameter int N_PAIRS   = 128,
  parameter int ZETA_BASE = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [6:0]  o_a_addr,
  input  logic [23:0] i_a_data,
  output logic [6:0]  o_b_addr,
  input  logic [23:0] i_b_data,
  output logic [6:0]  o_zeta_addr,
  input  logic [11:0] i_zeta,
  output logic        o_bm_en,
  output logic [11:0] o_bm_p_h,
  output logic [11:0] o_bm_p_l,
  output logic [11:0] o_bm_q_h,
  output logic [11:0] o_bm_q_l,
  output logic [11:0] o_bm_zeta,
  input  logic [11:0] i_bm_r_h,
  input  logic [11:0] i_bm_r_l,
  input  logic        i_bm_done,
  output logic        o_r_we,
  output logic [6:0]  o_r_addr,
  output logic [23:0] o_r_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_RUN,
    S_WR,
    S_FIN
  } state_t;

  localparam logic [11:0] Q12    = 12'(Q);
  localparam logic [6:0]  LAST_K = 7'(N_PAIRS - 1);
  localparam logic [6:0]  ZBASE  = 7'(ZETA_BASE);

  state_t      state;
  logic [6:0]  k;
  logic [11:0] zeta_eff;

  // All RAM ports share the pair counter; the zeta ROM is addressed per pair-of-pairs
  // and parked at 0 while idle so every output reads 0 out of reset.
  assign o_a_addr    = k;
  assign o_b_addr    = k;
  assign o_r_addr    = k;
  assign o_zeta_addr = o_busy ? (ZBASE + {1'b0, k[6:1]}) : 7'd0;

  // Odd pairs use -zeta mod Q; zero stays zero so the result never equals Q.
  always_comb begin
    zeta_eff = i_zeta;
    if (k[0] && (i_zeta != 12'd0)) begin
      zeta_eff = Q12 - i_zeta;
    end
  end

  // Main sequencer: read pair, latch operands, hold them through basemul, write result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      k         <= 7'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_bm_en   <= 1'b0;
      o_bm_p_h  <= 12'd0;
      o_bm_p_l  <= 12'd0;
      o_bm_q_h  <= 12'd0;
      o_bm_q_l  <= 12'd0;
      o_bm_zeta <= 12'd0;
      o_r_we    <= 1'b0;
      o_r_data  <= 24'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            k      <= 7'd0;
            o_busy <= 1'b1;
            state  <= S_RD;
          end
        end
        S_RD: begin
          state <= S_LAT;
        end
        S_LAT: begin
          o_bm_p_h  <= i_a_data[23:12];
          o_bm_p_l  <= i_a_data[11:0];
          o_bm_q_h  <= i_b_data[23:12];
          o_bm_q_l  <= i_b_data[11:0];
          o_bm_zeta <= zeta_eff;
          o_bm_en   <= 1'b1;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (i_bm_done) begin
            o_r_data <= {i_bm_r_h, i_bm_r_l};
            o_r_we   <= 1'b1;
            o_bm_en  <= 1'b0;
            state    <= S_WR;
          end
        end
        S_WR: begin
          o_r_we <= 1'b0;
          if (k == LAST_K) begin
            o_bm_p_h  <= 12'd0;
            o_bm_p_l  <= 12'd0;
            o_bm_q_h  <= 12'd0;
            o_bm_q_l  <= 12'd0;
            o_bm_zeta <= 12'd0;
            o_done    <= 1'b1;
            state     <= S_FIN;
          end else begin
            k     <= k + 7'd1;
            state <= S_RD;
          end
        end
        S_FIN: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          k      <= 7'd0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_basemul_ctrl.sv
// tb/tb_basemul_ctrl.sv - self-checking bench for basemul_ctrl with RAM/ROM and basemul models
`timescale 1ns/1ps
module tb_basemul_ctrl;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, bm_en, r_we;
  logic [6:0]  a_addr, b_addr, z_addr, r_addr;
  logic [23:0] a_data, b_data, r_data;
  logic [11:0] zeta;
  logic [11:0] p_h, p_l, q_h, q_l, bz;
  logic [11:0] r_h, r_l;
  logic        bm_done;

  int checks = 0;
  int errors = 0;

  logic [23:0] a_mem [128];
  logic [23:0] b_mem [128];
  logic [23:0] r_mem [128];
  logic [23:0] a_orig [128];
  logic [11:0] rom   [128];
  bit          inplace = 1'b0;
  bit          real_mode = 1'b0;

  logic [6:0]  wr_addr_q [$];
  logic [23:0] wr_data_q [$];
  int          done_cnt = 0;
  bit          prev_en = 1'b0;
  bit          prev_done = 1'b0;
  logic [59:0] held;
  int          cnt = 0;

  basemul_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_a_addr    (a_addr),
    .i_a_data    (a_data),
    .o_b_addr    (b_addr),
    .i_b_data    (b_data),
    .o_zeta_addr (z_addr),
    .i_zeta      (zeta),
    .o_bm_en     (bm_en),
    .o_bm_p_h    (p_h),
    .o_bm_p_l    (p_l),
    .o_bm_q_h    (q_h),
    .o_bm_q_l    (q_l),
    .o_bm_zeta   (bz),
    .i_bm_r_h    (r_h),
    .i_bm_r_l    (r_l),
    .i_bm_done   (bm_done),
    .o_r_we      (r_we),
    .o_r_addr    (r_addr),
    .o_r_data    (r_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAMs and ROM with one cycle of latency
  always @(posedge clk) begin
    a_data <= a_mem[a_addr];
    b_data <= b_mem[b_addr];
    zeta   <= rom[z_addr];
  end

  // Basemul model: fixed latency; stub arithmetic or the real Kyber pair product
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 0;
      bm_done <= 1'b0;
      r_h     <= 12'd0;
      r_l     <= 12'd0;
    end else begin
      bm_done <= 1'b0;
      if (cnt == 0) begin
        if (bm_en && !bm_done) cnt <= 1;
      end else if (cnt == 5) begin
        cnt     <= 0;
        bm_done <= 1'b1;
        if (real_mode) begin
          r_h <= 12'((int'(p_l) * int'(q_h) + int'(p_h) * int'(q_l)) % Q);
          r_l <= 12'((int'(p_l) * int'(q_l) + ((int'(p_h) * int'(q_h)) % Q) * int'(bz)) % Q);
        end else begin
          r_h <= p_h + q_h;
          r_l <= bz;
        end
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] gold(input logic [23:0] a, input logic [23:0] b,
                                       input int k, input bit stub);
    int z, ah, al, bh, bl;
    z = int'(rom[64 + k / 2]);
    if (k % 2 == 1) z = (Q - z) % Q;
    ah = int'(a[23:12]); al = int'(a[11:0]);
    bh = int'(b[23:12]); bl = int'(b[11:0]);
    if (stub) return {12'((ah + bh) % 4096), 12'(z)};
    return {12'((al * bh + ah * bl) % Q), 12'((al * bl + ((ah * bh) % Q) * z) % Q)};
  endfunction

  // One clock: sample at negedge, commit result writes, check basemul operand hold rules
  task automatic step();
    @(negedge clk);
    if (r_we) begin
      wr_addr_q.push_back(r_addr);
      wr_data_q.push_back(r_data);
      if (inplace) a_mem[r_addr] = r_data;
      else         r_mem[r_addr] = r_data;
    end
    if (done) done_cnt++;
    if (prev_done) chk("en_low_after_done", 64'(bm_en), 64'd0);
    else if (prev_en) chk("en_held_in_run", 64'(bm_en), 64'd1);
    if (bm_en && prev_en && !prev_done) chk("operands_hold", 64'({p_h, p_l, q_h, q_l, bz}), 64'(held));
    if (bm_en && !prev_en) held = {p_h, p_l, q_h, q_l, bz};
    prev_en   = bm_en;
    prev_done = bm_done;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 128; i++) begin
      a_mem[i]  = {12'($urandom_range(0, Q - 1)), 12'($urandom_range(0, Q - 1))};
      b_mem[i]  = {12'($urandom_range(0, Q - 1)), 12'($urandom_range(0, Q - 1))};
      r_mem[i]  = 24'd0;
      a_orig[i] = a_mem[i];
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, done, bm_en, r_we}), 64'd0);
    chk({tag, "_addr"}, 64'({a_addr, b_addr, z_addr, r_addr}), 64'd0);
    chk({tag, "_ops"},  64'({p_h, p_l, q_h, q_l, bz}), 64'd0);
  endtask

  task automatic run_product(input int pulse_k);
    int  n;
    int  d0;
    bit  pulsed;
    d0 = done_cnt;
    pulsed = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    while (done_cnt == d0 && n < 6000) begin
      if (start) start = 1'b0;
      else if (pulse_k >= 0 && !pulsed && int'(a_addr) == pulse_k) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      step();
      n++;
    end
    start = 1'b0;
    chk("run_timeout", 64'(done_cnt == d0), 64'd0);
    chk("busy_in_fin", 64'(busy), 64'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_fin_ignored", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
    step();
    chk("idle_after_fin", 64'(busy), 64'd0);
    chk("single_done_pulse", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_writes(input int base, input string tag);
    chk({tag, "_write_count"}, 64'(wr_addr_q.size() - base), 64'd128);
    for (int i = 0; i < 128 && base + i < wr_addr_q.size(); i++)
      chk({tag, "_write_addr"}, 64'(wr_addr_q[base + i]), 64'(i));
  endtask

  initial begin
    int base;
    int n;

    for (int i = 0; i < 128; i++) rom[i] = 12'($urandom_range(0, Q - 1));
    rom[64] = 12'd2226;
    rom[65] = 12'd0;
    load_mem();

    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    step();
    check_zero("idle");

    // Stub basemul full run with a stray start at k=40
    base = wr_addr_q.size();
    run_product(40);
    check_writes(base, "stub");
    if (wr_data_q.size() >= base + 4) begin
      chk("k0_zeta", 64'(wr_data_q[base][11:0]), 64'd2226);
      chk("k1_neg_zeta", 64'(wr_data_q[base + 1][11:0]), 64'd1103);
      chk("k3_zero_zeta", 64'(wr_data_q[base + 3][11:0]), 64'd0);
    end
    for (int i = 0; i < 128; i++)
      chk("stub_result", 64'(r_mem[i]), 64'(gold(a_mem[i], b_mem[i], i, 1'b1)));
    check_zero("after_run");

    // Asynchronous reset while running pair 10
    base = wr_addr_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(int'(a_addr) == 10 && bm_en) && n < 2000) begin
      step();
      n++;
    end
    chk("reach_k10_timeout", 64'(n >= 2000), 64'd0);
    #1 rst = 1'b1;
    #1 check_zero("midrun_reset");
    prev_en   = 1'b0;
    prev_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("midrun_write_count", 64'(wr_addr_q.size() - base), 64'd10);
    if (wr_addr_q.size() > 0)
      chk("midrun_last_addr", 64'(wr_addr_q[wr_addr_q.size() - 1]), 64'd9);
    chk("idle_after_reset", 64'(busy), 64'd0);

    // Real basemul against golden pointwise product
    real_mode = 1'b1;
    load_mem();
    base = wr_addr_q.size();
    run_product(-1);
    check_writes(base, "real");
    for (int i = 0; i < 128; i++)
      chk("real_result", 64'(r_mem[i]), 64'(gold(a_mem[i], b_mem[i], i, 1'b0)));

    // In-place product: result RAM aliases A
    inplace = 1'b1;
    load_mem();
    base = wr_addr_q.size();
    run_product(-1);
    check_writes(base, "inplace");
    for (int i = 0; i < 128; i++)
      chk("inplace_result", 64'(a_mem[i]), 64'(gold(a_orig[i], b_mem[i], i, 1'b0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
